// File: rtl/uram_pkg.sv
// Shared constants and types for the UltraRAM array: the physical bank geometry
// and the clear-sweep state encoding.
package uram_pkg;

   localparam int unsigned URAM_DEPTH  = 4096;
   localparam int unsigned URAM_W      = 72;
   localparam int unsigned URAM_BYTE_W = 9;
   localparam int unsigned URAM_AW     = 12;
   localparam int unsigned URAM_NBE    = URAM_W / URAM_BYTE_W;

   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      READY = 1'b1
   } clr_state_t;

   function automatic int unsigned div_ceil(input int unsigned a, input int unsigned b);
      return (a + b - 1) / b;
   endfunction

endpackage

// File: rtl/uram_bank.sv
// One 4096x72 UltraRAM bank with 9-bit byte write enables and a read-first,
// ren-gated output register. The register holds its value while ren is low.
module uram_bank
   import uram_pkg::*;
(
   input  logic                clk,
   input  logic                wen,
   input  logic [URAM_NBE-1:0] wbe,
   input  logic [URAM_AW-1:0]  waddr,
   input  logic [URAM_W-1:0]   wdata,
   input  logic                ren,
   input  logic [URAM_AW-1:0]  raddr,
   output logic [URAM_W-1:0]   rdata
);

   (* ram_style = "ultra" *) logic [URAM_W-1:0] mem_q [URAM_DEPTH];
   logic [URAM_W-1:0] rdata_q;

   // Read and write share one block so a same-address collision returns the old word.
   always_ff @(posedge clk) begin
      if (ren) begin
         rdata_q <= mem_q[raddr];
      end
      if (wen) begin
         for (int i = 0; i < URAM_NBE; i++) begin
            if (wbe[i]) begin
               mem_q[waddr][i*URAM_BYTE_W +: URAM_BYTE_W] <= wdata[i*URAM_BYTE_W +: URAM_BYTE_W];
            end
         end
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/uram_array.sv
// Parametrised UltraRAM array: NB rows of banks stacked in depth, NC columns side by
// side in width. Adds a pipelined row-select mux, optional mux/output registers with
// a matching read-valid strobe, and a zeroing sweep after reset.
module uram_array
   import uram_pkg::*;
#(
   parameter int unsigned DW           = 72,
   parameter int unsigned DEPTH        = 8192,
   parameter int unsigned MUX_REG      = 1,
   parameter int unsigned OREG         = 0,
   parameter int unsigned CLEAR_ON_RST = 1,
   localparam int unsigned AW          = $clog2(DEPTH),
   localparam int unsigned NBE         = DW / URAM_BYTE_W
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [DW-1:0]  wdata,
   input  logic [NBE-1:0] wbe,
   input  logic [AW-1:0]  waddr,
   input  logic           wen,
   input  logic [AW-1:0]  raddr,
   input  logic           ren,
   output logic [DW-1:0]  rdata,
   output logic           rvalid,
   output logic           busy
);

   localparam int unsigned NB  = DEPTH / URAM_DEPTH;
   localparam int unsigned NC  = div_ceil(DW, URAM_W);
   localparam int unsigned PW  = NC * URAM_W;
   localparam int unsigned PBE = NC * URAM_NBE;
   localparam int unsigned RW  = (NB > 1) ? $clog2(NB) : 1;

   // ---------------- clear sweep ----------------
   clr_state_t         state_q, state_d;
   logic [URAM_AW-1:0] cnt_q, cnt_d;

   // Walk cnt over every in-row address once, then hand the array to users.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == CLEAR) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == URAM_AW'(URAM_DEPTH - 1)) begin
            state_d = READY;
         end
      end
   end

   // Any reset restarts the sweep from address zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= (CLEAR_ON_RST != 0) ? CLEAR : READY;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy = (state_q == CLEAR);

   // ---------------- request decode ----------------
   logic          wr_ok, rd_acc, rd_in;
   logic [AW-1:0] wrow, rrow;

   assign wr_ok  = wen && !busy && (32'(waddr) < DEPTH);
   assign rd_acc = ren && !busy;
   assign rd_in  = (32'(raddr) < DEPTH);
   assign wrow   = waddr >> URAM_AW;
   assign rrow   = raddr >> URAM_AW;

   logic [PW-1:0]      wdata_pad, bank_wdata;
   logic [PBE-1:0]     wbe_pad, bank_wbe;
   logic [URAM_AW-1:0] bank_waddr;

   // During the sweep every bank writes zero with all bytes enabled at cnt.
   always_comb begin
      wdata_pad         = '0;
      wdata_pad[DW-1:0] = wdata;
      wbe_pad           = '0;
      wbe_pad[NBE-1:0]  = wbe;
      if (busy) begin
         bank_wdata = '0;
         bank_wbe   = '1;
         bank_waddr = cnt_q;
      end else begin
         bank_wdata = wdata_pad;
         bank_wbe   = wbe_pad;
         bank_waddr = waddr[URAM_AW-1:0];
      end
   end

   // ---------------- bank grid ----------------
   logic [PW-1:0] bank_rdata [NB];

   for (genvar r = 0; r < NB; r++) begin : g_row
      logic row_wen, row_ren;
      assign row_wen = busy || (wr_ok && (wrow == AW'(r)));
      assign row_ren = rd_acc && rd_in && (rrow == AW'(r));
      for (genvar c = 0; c < NC; c++) begin : g_col
         uram_bank u_bank (
            .clk   (clk),
            .wen   (row_wen),
            .wbe   (bank_wbe[c*URAM_NBE +: URAM_NBE]),
            .waddr (bank_waddr),
            .wdata (bank_wdata[c*URAM_W +: URAM_W]),
            .ren   (row_ren),
            .raddr (raddr[URAM_AW-1:0]),
            .rdata (bank_rdata[r][c*URAM_W +: URAM_W])
         );
      end
   end

   // ---------------- read pipeline ----------------
   logic          s1_valid_q, s1_oor_q;
   logic [RW-1:0] s1_sel_q;

   // Row select travels with the bank read; oor resets high so rdata reads 0 after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_oor_q   <= 1'b1;
         s1_sel_q   <= '0;
      end else begin
         s1_valid_q <= rd_acc;
         if (rd_acc) begin
            s1_oor_q <= !rd_in;
            s1_sel_q <= RW'(rrow);
         end
      end
   end

   logic [PW-1:0] mux_full;
   logic [DW-1:0] mux_data;

   // Select the row captured at acceptance; out-of-range reads yield zero.
   always_comb begin
      mux_full = '0;
      if (!s1_oor_q) begin
         for (int r = 0; r < NB; r++) begin
            if (s1_sel_q == RW'(r)) begin
               mux_full = bank_rdata[r];
            end
         end
      end
      mux_data = mux_full[DW-1:0];
   end

   logic          s2_valid, s3_valid;
   logic [DW-1:0] s2_data, s3_data;

   if (MUX_REG != 0) begin : g_mux_reg
      logic          valid_q;
      logic [DW-1:0] data_q;
      // Register the mux output only when a read completes, so it holds otherwise.
      always_ff @(posedge clk) begin
         if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
         end else begin
            valid_q <= s1_valid_q;
            if (s1_valid_q) begin
               data_q <= mux_data;
            end
         end
      end
      assign s2_valid = valid_q;
      assign s2_data  = data_q;
   end else begin : g_no_mux_reg
      assign s2_valid = s1_valid_q;
      assign s2_data  = mux_data;
   end

   if (OREG != 0) begin : g_oreg
      logic          valid_q;
      logic [DW-1:0] data_q;
      // Final output register, loaded only on a completing read.
      always_ff @(posedge clk) begin
         if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
         end else begin
            valid_q <= s2_valid;
            if (s2_valid) begin
               data_q <= s2_data;
            end
         end
      end
      assign s3_valid = valid_q;
      assign s3_data  = data_q;
   end else begin : g_no_oreg
      assign s3_valid = s2_valid;
      assign s3_data  = s2_data;
   end

   assign rdata  = s3_data;
   assign rvalid = s3_valid;

endmodule

// File: tb/tb_uram_array.sv
// Bench for uram_array: four instances (all MUX_REG/OREG combinations, DEPTH=12288)
// share one stimulus stream and are checked against an array-based memory model.
module tb_uram_array;

   localparam int unsigned DW     = 72;
   localparam int unsigned DEPTH  = 12288;
   localparam int unsigned AW     = 14;
   localparam int unsigned NBE    = 8;
   localparam int          NI     = 4;
   localparam int          MAXOPS = 256;
   localparam int          LAT [NI] = '{1, 2, 2, 3};

   logic           clk = 1'b0;
   logic           rst;
   logic [DW-1:0]  wdata;
   logic [NBE-1:0] wbe;
   logic [AW-1:0]  waddr, raddr;
   logic           wen, ren;
   logic [DW-1:0]  rd [NI];
   logic           rv [NI];
   logic           bz [NI];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   uram_array #(.DW(DW), .DEPTH(DEPTH), .MUX_REG(0), .OREG(0), .CLEAR_ON_RST(1)) u_dut0 (
      .clk(clk), .rst(rst), .wdata(wdata), .wbe(wbe), .waddr(waddr), .wen(wen),
      .raddr(raddr), .ren(ren), .rdata(rd[0]), .rvalid(rv[0]), .busy(bz[0]));
   uram_array #(.DW(DW), .DEPTH(DEPTH), .MUX_REG(0), .OREG(1), .CLEAR_ON_RST(1)) u_dut1 (
      .clk(clk), .rst(rst), .wdata(wdata), .wbe(wbe), .waddr(waddr), .wen(wen),
      .raddr(raddr), .ren(ren), .rdata(rd[1]), .rvalid(rv[1]), .busy(bz[1]));
   uram_array #(.DW(DW), .DEPTH(DEPTH), .MUX_REG(1), .OREG(0), .CLEAR_ON_RST(1)) u_dut2 (
      .clk(clk), .rst(rst), .wdata(wdata), .wbe(wbe), .waddr(waddr), .wen(wen),
      .raddr(raddr), .ren(ren), .rdata(rd[2]), .rvalid(rv[2]), .busy(bz[2]));
   uram_array #(.DW(DW), .DEPTH(DEPTH), .MUX_REG(1), .OREG(1), .CLEAR_ON_RST(1)) u_dut3 (
      .clk(clk), .rst(rst), .wdata(wdata), .wbe(wbe), .waddr(waddr), .wen(wen),
      .raddr(raddr), .ren(ren), .rdata(rd[3]), .rvalid(rv[3]), .busy(bz[3]));

   // ---------------- reference model and op list ----------------
   logic [DW-1:0]  ref_mem [DEPTH];

   logic           op_wen [MAXOPS];
   int             op_waddr [MAXOPS];
   logic [DW-1:0]  op_wdata [MAXOPS];
   logic [NBE-1:0] op_wbe [MAXOPS];
   logic           op_ren [MAXOPS];
   int             op_raddr [MAXOPS];
   int             n_ops;

   logic [DW-1:0]  exp_d [MAXOPS];
   int             exp_c [MAXOPS];
   int             exp_n;
   logic [DW-1:0]  obs_d [NI][MAXOPS];
   int             obs_c [NI][MAXOPS];
   int             obs_n [NI];

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                          input logic [NBE-1:0] be);
      logic [DW-1:0] res = old_w;
      for (int i = 0; i < NBE; i++) begin
         if (be[i]) res[i*9 +: 9] = new_w[i*9 +: 9];
      end
      return res;
   endfunction

   task automatic zero_model();
      for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
   endtask

   task automatic add_op(input logic w, input int wa, input logic [DW-1:0] wd,
                         input logic [NBE-1:0] be, input logic r, input int ra);
      op_wen[n_ops]   = w;
      op_waddr[n_ops] = wa;
      op_wdata[n_ops] = wd;
      op_wbe[n_ops]   = be;
      op_ren[n_ops]   = r;
      op_raddr[n_ops] = ra;
      n_ops++;
   endtask

   task automatic idle();
      wen = 1'b0;
      ren = 1'b0;
   endtask

   // Predict reads from the model (read-first), then drive one op per cycle and record
   // every rvalid pulse with the cycle it appeared in.
   task automatic run_ops();
      exp_n = 0;
      for (int i = 0; i < NI; i++) obs_n[i] = 0;
      for (int k = 0; k < n_ops; k++) begin
         if (op_ren[k]) begin
            exp_d[exp_n] = (op_raddr[k] < DEPTH) ? ref_mem[op_raddr[k]] : '0;
            exp_c[exp_n] = k;
            exp_n++;
         end
         if (op_wen[k] && op_waddr[k] < DEPTH)
            ref_mem[op_waddr[k]] = merge(ref_mem[op_waddr[k]], op_wdata[k], op_wbe[k]);
      end
      for (int c = 0; c < n_ops + 6; c++) begin
         @(posedge clk); #1;
         if (c < n_ops) begin
            wen   = op_wen[c];
            waddr = op_waddr[c][AW-1:0];
            wdata = op_wdata[c];
            wbe   = op_wbe[c];
            ren   = op_ren[c];
            raddr = op_raddr[c][AW-1:0];
         end else begin
            idle();
         end
         @(negedge clk);
         for (int i = 0; i < NI; i++) begin
            if (rv[i] === 1'b1 && obs_n[i] < MAXOPS) begin
               obs_d[i][obs_n[i]] = rd[i];
               obs_c[i][obs_n[i]] = c;
               obs_n[i]++;
            end
         end
      end
      n_ops = 0;
   endtask

   function automatic logic [DW-1:0] rand_word();
      logic [95:0] t = {$urandom(), $urandom(), $urandom()};
      return t[DW-1:0];
   endfunction

   function automatic int pick_addr();
      int sel = $urandom_range(0, 7);
      case (sel)
         0: return $urandom_range(0, 16383);
         1: return 4095;
         2: return 4096;
         3: return 12287;
         4: return $urandom_range(12286, 12290);
         default: return $urandom_range(0, 15);
      endcase
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      idle();
      wdata = '0; wbe = '0; waddr = '0; raddr = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         checks++;
         if (bz[i] !== 1'b1 || rv[i] !== 1'b0 || rd[i] !== '0) begin
            errors++;
            $display("FAIL reset inst%0d: busy=%b rvalid=%b rdata=%h, expected busy=1 rvalid=0 rdata=0",
                     i, bz[i], rv[i], rd[i]);
         end
      end
   endtask

   // Release rst with ren held at addr 5; busy must cover cycles 1..4096 exactly.
   task automatic sweep_and_check(input string name, input logic hold_ren);
      int bad_busy = 0;
      int bad_rv = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      ren = hold_ren;
      raddr = 5;
      for (int c = 1; c <= 4096; c++) begin
         @(negedge clk);
         for (int i = 0; i < NI; i++) begin
            if (bz[i] !== 1'b1) bad_busy++;
            if (rv[i] !== 1'b0) bad_rv++;
         end
         @(posedge clk); #1;
      end
      idle();
      checks++;
      if (bad_busy != 0) begin
         errors++;
         $display("FAIL %s busy_low_during_sweep: %0d samples low, expected 0", name, bad_busy);
      end
      checks++;
      if (bad_rv != 0) begin
         errors++;
         $display("FAIL %s rvalid_during_sweep: %0d pulses, expected 0", name, bad_rv);
      end
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         checks++;
         if (bz[i] !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_cycle_4097 inst%0d: got %b expected 0", name, i, bz[i]);
         end
      end
      zero_model();
   endtask

   task automatic test_clear_sweep();
      zero_model();
      sweep_and_check("clear_sweep", 1'b1);
      add_op(0, 0, '0, '0, 1, 5);
      run_ops();
      for (int i = 0; i < NI; i++) begin
         checks++;
         if (obs_n[i] !== exp_n || obs_d[i][0] !== '0 || obs_c[i][0] !== LAT[i]) begin
            errors++;
            $display("FAIL clear_read5 inst%0d: got n=%0d data=%h cyc=%0d expected n=%0d data=0 cyc=%0d",
                     i, obs_n[i], obs_d[i][0], obs_c[i][0], exp_n, LAT[i]);
         end
      end
   endtask

   task automatic test_byte_enables();
      add_op(1, 100, '1, '1, 0, 0);
      add_op(1, 100, '0, 8'b0000_0001, 0, 0);
      add_op(0, 0, '0, '0, 1, 100);
      run_ops();
      for (int i = 0; i < NI; i++) begin
         checks++;
         if (obs_n[i] !== 1 || obs_d[i][0] !== {{63{1'b1}}, 9'h000} || obs_c[i][0] !== 2 + LAT[i]) begin
            errors++;
            $display("FAIL byte_en inst%0d: got n=%0d data=%h cyc=%0d expected 1 data=%h cyc=%0d",
                     i, obs_n[i], obs_d[i][0], obs_c[i][0], {{63{1'b1}}, 9'h000}, 2 + LAT[i]);
         end
      end
   endtask

   task automatic test_latency();
      for (int a = 0; a < 4; a++) add_op(1, a, DW'(8'h11 * (a + 1)), '1, 0, 0);
      for (int a = 0; a < 4; a++) add_op(0, 0, '0, '0, 1, a);
      run_ops();
      for (int i = 0; i < NI; i++) begin
         checks++;
         if (obs_n[i] !== exp_n) begin
            errors++;
            $display("FAIL latency_count inst%0d: got %0d pulses expected %0d", i, obs_n[i], exp_n);
         end
         for (int k = 0; k < exp_n && k < obs_n[i]; k++) begin
            checks++;
            if (obs_d[i][k] !== exp_d[k] || obs_c[i][k] !== exp_c[k] + LAT[i]) begin
               errors++;
               $display("FAIL latency read%0d inst%0d: got %h @%0d expected %h @%0d",
                        k, i, obs_d[i][k], obs_c[i][k], exp_d[k], exp_c[k] + LAT[i]);
            end
         end
      end
      // No read completes now: rdata must still show the last result.
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         checks++;
         if (rd[i] !== DW'(8'h44)) begin
            errors++;
            $display("FAIL rdata_hold inst%0d: got %h expected %h", i, rd[i], DW'(8'h44));
         end
      end
   endtask

   task automatic test_bank_boundary();
      add_op(1, 4095, DW'(4'hA), '1, 0, 0);
      add_op(1, 4096, DW'(4'hB), '1, 0, 0);
      add_op(1, 12287, DW'(4'hC), '1, 0, 0);
      add_op(1, 12288, DW'(4'hD), '1, 0, 0);
      add_op(0, 0, '0, '0, 1, 4095);
      add_op(0, 0, '0, '0, 1, 4096);
      add_op(0, 0, '0, '0, 1, 12287);
      add_op(0, 0, '0, '0, 1, 12288);
      add_op(0, 0, '0, '0, 1, 0);
      add_op(0, 0, '0, '0, 1, 16383);
      run_ops();
      for (int i = 0; i < NI; i++) begin
         checks++;
         if (obs_n[i] !== exp_n) begin
            errors++;
            $display("FAIL boundary_count inst%0d: got %0d pulses expected %0d", i, obs_n[i], exp_n);
         end
         for (int k = 0; k < exp_n && k < obs_n[i]; k++) begin
            checks++;
            if (obs_d[i][k] !== exp_d[k] || obs_c[i][k] !== exp_c[k] + LAT[i]) begin
               errors++;
               $display("FAIL boundary read%0d inst%0d: got %h @%0d expected %h @%0d",
                        k, i, obs_d[i][k], obs_c[i][k], exp_d[k], exp_c[k] + LAT[i]);
            end
         end
      end
   endtask

   task automatic test_collision();
      add_op(1, 7, DW'(4'h5), '1, 0, 0);
      add_op(1, 7, DW'(4'h9), '1, 1, 7);
      add_op(0, 0, '0, '0, 1, 7);
      run_ops();
      for (int i = 0; i < NI; i++) begin
         checks++;
         if (obs_n[i] !== 2 || obs_d[i][0] !== DW'(4'h5) || obs_d[i][1] !== DW'(4'h9)) begin
            errors++;
            $display("FAIL collision inst%0d: got n=%0d first=%h second=%h expected 2 first=5 second=9",
                     i, obs_n[i], obs_d[i][0], obs_d[i][1]);
         end
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 200; k++) begin
         add_op(($urandom_range(0, 1) == 1), pick_addr(), rand_word(), NBE'($urandom()),
                ($urandom_range(0, 4) < 3), pick_addr());
      end
      run_ops();
      for (int i = 0; i < NI; i++) begin
         checks++;
         if (obs_n[i] !== exp_n) begin
            errors++;
            $display("FAIL random_count inst%0d: got %0d pulses expected %0d", i, obs_n[i], exp_n);
         end
         for (int k = 0; k < exp_n && k < obs_n[i]; k++) begin
            checks++;
            if (obs_d[i][k] !== exp_d[k] || obs_c[i][k] !== exp_c[k] + LAT[i]) begin
               errors++;
               $display("FAIL random read%0d inst%0d: got %h @%0d expected %h @%0d",
                        k, i, obs_d[i][k], obs_c[i][k], exp_d[k], exp_c[k] + LAT[i]);
            end
         end
      end
   endtask

   // Reset again at cnt=2000: the sweep must restart and then leave everything zeroed.
   task automatic test_reset_mid_sweep();
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (2000) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      sweep_and_check("mid_sweep", 1'b0);
      add_op(0, 0, '0, '0, 1, 100);
      add_op(0, 0, '0, '0, 1, 4095);
      add_op(0, 0, '0, '0, 1, 4096);
      add_op(0, 0, '0, '0, 1, 12287);
      add_op(0, 0, '0, '0, 1, 7);
      add_op(0, 0, '0, '0, 1, 3);
      run_ops();
      for (int i = 0; i < NI; i++) begin
         checks++;
         if (obs_n[i] !== exp_n) begin
            errors++;
            $display("FAIL cleared_count inst%0d: got %0d pulses expected %0d", i, obs_n[i], exp_n);
         end
         for (int k = 0; k < exp_n && k < obs_n[i]; k++) begin
            checks++;
            if (obs_d[i][k] !== exp_d[k]) begin
               errors++;
               $display("FAIL cleared read%0d inst%0d: got %h expected %h",
                        k, i, obs_d[i][k], exp_d[k]);
            end
         end
      end
   endtask

   task automatic test_reset_inflight();
      int bad_rv = 0;
      @(posedge clk); #1;
      ren = 1'b1;
      raddr = 1;
      @(posedge clk); #1;
      raddr = 2;
      @(posedge clk); #1;
      raddr = 3;
      rst = 1'b1;
      @(posedge clk); #1;
      idle();
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         checks++;
         if (rd[i] !== '0 || rv[i] !== 1'b0) begin
            errors++;
            $display("FAIL inflight_reset inst%0d: rdata=%h rvalid=%b expected 0 and 0", i, rd[i], rv[i]);
         end
      end
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (8) begin
         @(negedge clk);
         for (int i = 0; i < NI; i++) if (rv[i] !== 1'b0) bad_rv++;
      end
      checks++;
      if (bad_rv != 0) begin
         errors++;
         $display("FAIL inflight_rvalid: %0d pulses after reset, expected 0", bad_rv);
      end
   endtask

   initial begin
      n_ops = 0;
      test_reset();
      test_clear_sweep();
      test_byte_enables();
      test_latency();
      test_bank_boundary();
      test_collision();
      test_random();
      test_reset_mid_sweep();
      test_reset_inflight();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
